button_mmio: RTL and testbench
==============================

# button_mmio

Memory-mapped input block for the processor's game I/O, generalising the single `fd_jio` button line to `N_BTN` debounced channels. Each channel is synchronised, debounced and edge-detected; rising edges set sticky event bits that software reads and clears through the data-memory port. It sits beside `RAM` on the dmem bus, decoding a small register window and returning read data with the same one-cycle latency as `RAM`.

## Interface
- `N_BTN`, 4: number of button channels, 1..32.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required before the debounced level changes, ≥1.
- `BASE_ADDR`, 12'hFF0: word address of register 0. The window is 4 words, aligned to 4.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  N_BTN  raw, asynchronous, bouncy button inputs, active-high.
- `addr`  in  12  dmem word address (`memAddr[11:0]`).
- `wren`  in  1  dmem write strobe (`mwe`).
- `data_in`  in  32  dmem write data.
- `sel`  out  1  combinational: `addr` lies in the window. The top level uses it to steer the read mux.
- `q`  out  32  registered read data for the address presented in the previous cycle.
- `level`  out  N_BTN  debounced button levels.
- `irq`  out  1  registered: `|(EVENT & MASK)`.

## Operation
- Per channel:
  - Two-flop synchroniser on `btn_raw`.
  - Debounce counter. When the synchronised input equals `level`, the counter is cleared.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1`, `level` toggles and the counter clears.
  - Any return to the old value before that point clears the counter.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. The counter saturates and never wraps.
- A rising edge of `level` (0→1) sets the channel's `EVENT` bit. Falling edges set nothing.
- Registers (offset from `BASE_ADDR`). Bits ≥ `N_BTN` read 0 and ignore writes.
  - 0 `LEVEL`, read-only: debounced levels.
  - 1 `EVENT`, read and write-1-to-clear: sticky rising-edge bits.
  - 2 `MASK`, read/write: interrupt enables for `irq`.
  - 3 `COUNT`, read-only: a 32-bit count of all rising edges on all channels. It wraps at 2^32 and is cleared by writing any value.
- Writes take effect on the clock edge where `wren` is high and `sel` is high.
- Writes to `LEVEL` are ignored.
- Simultaneous events:
  - An EVENT set and a W1C clear of the same bit in the same cycle: the set wins and the bit stays 1.
  - A COUNT write and an edge in the same cycle: COUNT becomes the number of edges in that cycle (0..N_BTN), not 0.
- Multiple channels with rising edges in the same cycle all set their EVENT bits. COUNT adds the popcount of those edges.
- Reads have no side effects; clearing EVENT is explicit by W1C.

## Timing
- Reset (asynchronous, active-low) clears the synchronisers, counters, `level`, `EVENT`, `MASK`, `COUNT`, `q` and `irq` to 0.
- Reset asserted mid-debounce discards the partial count.
- Input-to-`level` latency is 2 synchroniser cycles plus `DEBOUNCE_CYCLES` cycles of stable input.
- `EVENT` sets on the cycle after `level` rises. `irq` follows `EVENT`/`MASK` by one cycle.
- `COUNT` updates on the same edge that sets `EVENT`.
- `q`:
  - `q` reflects the register state at the edge that samples `addr`, i.e. before any write on that same edge.
  - `q` returns 0 when the sampled address was outside the window.
- Write-to-read-back: a read addressed on cycle t+1 after a write on cycle t sees the new value.

## Structure
- Package `button_mmio_pkg` holds:
  - register offset constants `REG_LEVEL=2'd0`, `REG_EVENT=2'd1`, `REG_MASK=2'd2`, `REG_COUNT=2'd3`;
  - the window size constant, 4.
- Sub-module `button_debounce`, parameter `DEBOUNCE_CYCLES`:
  - contains the synchroniser, counter and level flop;
  - outputs `level` and a one-cycle `rise` pulse.
- `button_mmio` instantiates `N_BTN` of them in a generate loop and holds the register file, decode, edge counting and read mux.

## Test plan
- **Reset:** hold `reset`=0 with `btn_raw`=4'hF, then release → `level`=0, `q`=0, `irq`=0. `level[*]`=1 follows 2+`DEBOUNCE_CYCLES` cycles later.
- **Bounce rejection** (`DEBOUNCE_CYCLES`=8):
  - Toggle `btn_raw[0]` every 3 cycles for 40 cycles → `level[0]` stays 0 and `EVENT` stays 0.
  - Then hold it at 1 → `level[0]`=1 exactly 10 cycles after it settles. EVENT reads 32'h1 and COUNT reads 1.
- **W1C race:** make `EVENT`=4'b0011, then write 32'h3 to offset 1 on the same cycle ch1 rises again → `EVENT`=4'b0010.
- **IRQ masking:**
  - `MASK`=4'b0100 with a ch0 press → `irq`=0.
  - A subsequent ch2 press → `irq`=1 one cycle after EVENT[2] sets.
  - Writing 32'h4 to offset 1 → `irq`=0 two cycles later.
- **Simultaneous edges:** all 4 channels rise in the same cycle → EVENT=4'hF and COUNT increments by 4. Writing offset 3 with an edge present → COUNT=1.
- **Decode:** a read at `BASE_ADDR`-1 → `sel`=0 and `q`=0. A write of 32'hFFFF_FFFF to MASK with `N_BTN`=4 → MASK reads 32'h0000_000F.

Source files
------------

// File: rtl/button_mmio_pkg.sv
// button_mmio_pkg: register map and helpers shared by the button MMIO block.
package button_mmio_pkg;
  localparam logic [1:0] REG_LEVEL = 2'd0;
  localparam logic [1:0] REG_EVENT = 2'd1;
  localparam logic [1:0] REG_MASK  = 2'd2;
  localparam logic [1:0] REG_COUNT = 2'd3;
  localparam int WIN_WORDS = 4;
  function automatic logic [5:0] popcount(input logic [31:0] v);
    popcount = '0;
    for (int i = 0; i < 32; i++) popcount = popcount + 6'(v[i]);
  endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: two-flop synchroniser, stability counter and debounced level
// with a one-cycle rising-edge pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_level_d <= r_level;
      if (r_sync[1] == r_level) r_cnt <= '0;
      else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else if (r_cnt != '1) r_cnt <= r_cnt + CW'(1);
    end
  end
  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_d;
endmodule

// File: rtl/button_mmio.sv
// button_mmio: N_BTN debounced button channels with sticky rising-edge events,
// interrupt mask and edge counter behind a 4-word dmem register window.
module button_mmio
  import button_mmio_pkg::*;
#(
  parameter int          N_BTN           = 4,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [11:0] BASE_ADDR       = 12'hFF0
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [N_BTN-1:0] i_btn_raw,
  input  logic [11:0]      i_addr,
  input  logic             i_wren,
  input  logic [31:0]      i_data_in,
  output logic             o_sel,
  output logic [31:0]      o_q,
  output logic [N_BTN-1:0] o_level,
  output logic             o_irq
);
  localparam int OW = $clog2(WIN_WORDS);
  logic [N_BTN-1:0] w_level, w_rise, w_clr;
  logic [N_BTN-1:0] r_event, r_mask;
  logic [31:0]      r_count, r_q, w_rd;
  logic [OW-1:0]    w_off;
  logic             w_we, r_irq, w_unused;
  logic [5:0]       w_nrise;
  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .i_clock(i_clock),
      .i_reset(i_reset),
      .i_btn  (i_btn_raw[g]),
      .o_level(w_level[g]),
      .o_rise (w_rise[g])
    );
  end
  assign o_sel    = i_addr[11:OW] == BASE_ADDR[11:OW];
  assign w_off    = i_addr[OW-1:0];
  assign w_we     = i_wren & o_sel;
  assign w_clr    = (w_we && w_off == REG_EVENT) ? i_data_in[N_BTN-1:0] : '0;
  assign w_nrise  = popcount(32'(w_rise));
  assign w_unused = ^i_data_in;
  always_comb begin
    w_rd = w_off == REG_LEVEL ? 32'(w_level) :
           w_off == REG_EVENT ? 32'(r_event) :
           w_off == REG_MASK  ? 32'(r_mask)  : r_count;
  end
  // Edges win over same-cycle W1C clears and COUNT writes.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_event <= '0;
      r_mask  <= '0;
      r_count <= '0;
      r_q     <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_event <= (r_event & ~w_clr) | w_rise;
      if (w_we && w_off == REG_MASK) r_mask <= i_data_in[N_BTN-1:0];
      r_count <= (w_we && w_off == REG_COUNT) ? 32'(w_nrise) : r_count + 32'(w_nrise);
      r_q     <= o_sel ? w_rd : '0;
      r_irq   <= |(r_event & r_mask);
    end
  end
  assign o_q     = r_q;
  assign o_level = w_level;
  assign o_irq   = r_irq;
endmodule

// File: tb/tb_button_mmio.sv
// tb_button_mmio: directed tests for button_mmio with DEBOUNCE_CYCLES=8, N_BTN=4.
module tb_button_mmio;
  localparam logic [11:0] BASE = 12'hFF0;
  logic        clk = 1'b0, rst_n = 1'b0, wren = 1'b0, sel, irq;
  logic [3:0]  btn = 4'h0, level;
  logic [11:0] addr = BASE;
  logic [31:0] din = '0, q, d;
  int n_tests = 0, n_fail = 0;

  button_mmio #(.N_BTN(4), .DEBOUNCE_CYCLES(8), .BASE_ADDR(BASE)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_btn_raw(btn), .i_addr(addr), .i_wren(wren),
    .i_data_in(din), .o_sel(sel), .o_q(q), .o_level(level), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] off, output logic [31:0] v);
    addr = BASE + 12'(off);
    wren = 1'b0;
    tick();
    v = q;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] v);
    addr = BASE + 12'(off);
    din  = v;
    wren = 1'b1;
    tick();
    wren = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    btn   = 4'hF;
    tick(3);
    n_tests++; if (level !== 4'h0) begin n_fail++; $display("FAIL reset_level got %h exp 0", level); end
    n_tests++; if (q !== 32'h0) begin n_fail++; $display("FAIL reset_q got %h exp 0", q); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq); end
    rst_n = 1'b1;
    tick(9);
    n_tests++; if (level !== 4'h0) begin n_fail++; $display("FAIL reset_level_early got %h exp 0", level); end
    tick();
    n_tests++; if (level !== 4'hF) begin n_fail++; $display("FAIL reset_level_rise got %h exp f", level); end
    btn = 4'h0;
    tick(12);
    rd(2'd1, d);
    n_tests++; if (d !== 32'hF) begin n_fail++; $display("FAIL reset_event got %h exp f", d); end
    rd(2'd3, d);
    n_tests++; if (d !== 32'h4) begin n_fail++; $display("FAIL reset_count got %h exp 4", d); end
    wr(2'd1, 32'hF);
    wr(2'd3, 32'h0);
    rd(2'd1, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_all got %h exp 0", d); end
    rd(2'd3, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL count_clear got %h exp 0", d); end
  endtask

  task automatic test_bounce;
    logic bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) btn[0] = ~btn[0];
      tick();
      if (level[0] !== 1'b0) bad = 1'b1;
    end
    n_tests++; if (bad !== 1'b0) begin n_fail++; $display("FAIL bounce_level got %b exp 0", bad); end
    rd(2'd1, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL bounce_event got %h exp 0", d); end
    btn[0] = 1'b1;
    tick(9);
    n_tests++; if (level[0] !== 1'b0) begin n_fail++; $display("FAIL settle_early got %b exp 0", level[0]); end
    tick();
    n_tests++; if (level[0] !== 1'b1) begin n_fail++; $display("FAIL settle_level got %b exp 1", level[0]); end
    tick();
    rd(2'd1, d);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL settle_event got %h exp 1", d); end
    rd(2'd3, d);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL settle_count got %h exp 1", d); end
  endtask

  task automatic test_w1c_race;
    btn[1] = 1'b1;
    tick(11);
    rd(2'd1, d);
    n_tests++; if (d !== 32'h3) begin n_fail++; $display("FAIL w1c_setup got %h exp 3", d); end
    btn[1] = 1'b0;
    tick(12);
    btn[1] = 1'b1;
    tick(10);
    n_tests++; if (level[1] !== 1'b1) begin n_fail++; $display("FAIL w1c_level got %b exp 1", level[1]); end
    wr(2'd1, 32'h3);
    rd(2'd1, d);
    n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL w1c_race got %h exp 2", d); end
    rd(2'd3, d);
    n_tests++; if (d !== 32'h3) begin n_fail++; $display("FAIL w1c_count got %h exp 3", d); end
    btn = 4'h0;
    tick(12);
    wr(2'd1, 32'hF);
    wr(2'd3, 32'h0);
  endtask

  task automatic test_irq_mask;
    wr(2'd2, 32'h4);
    btn[0] = 1'b1;
    tick(14);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked got %b exp 0", irq); end
    rd(2'd1, d);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL irq_event0 got %h exp 1", d); end
    btn[2] = 1'b1;
    tick(11);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b exp 0", irq); end
    tick();
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b exp 1", irq); end
    wr(2'd1, 32'h4);
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold got %b exp 1", irq); end
    tick();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b exp 0", irq); end
    btn = 4'h0;
    tick(12);
    wr(2'd1, 32'hF);
    wr(2'd3, 32'h0);
    wr(2'd2, 32'h0);
  endtask

  task automatic test_simultaneous;
    btn = 4'hF;
    tick(10);
    n_tests++; if (level !== 4'hF) begin n_fail++; $display("FAIL simul_level got %h exp f", level); end
    tick();
    rd(2'd1, d);
    n_tests++; if (d !== 32'hF) begin n_fail++; $display("FAIL simul_event got %h exp f", d); end
    rd(2'd3, d);
    n_tests++; if (d !== 32'h4) begin n_fail++; $display("FAIL simul_count got %h exp 4", d); end
    btn = 4'h0;
    tick(12);
    wr(2'd1, 32'hF);
    btn = 4'h8;
    tick(10);
    wr(2'd3, 32'hDEAD_BEEF);
    rd(2'd3, d);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL count_write_race got %h exp 1", d); end
    rd(2'd1, d);
    n_tests++; if (d !== 32'h8) begin n_fail++; $display("FAIL simul_event3 got %h exp 8", d); end
  endtask

  task automatic test_decode;
    wr(2'd0, 32'h0);
    rd(2'd0, d);
    n_tests++; if (d !== 32'h8) begin n_fail++; $display("FAIL level_ro got %h exp 8", d); end
    addr = BASE - 12'd1;
    #1;
    n_tests++; if (sel !== 1'b0) begin n_fail++; $display("FAIL sel_below got %b exp 0", sel); end
    tick();
    n_tests++; if (q !== 32'h0) begin n_fail++; $display("FAIL q_outside got %h exp 0", q); end
    addr = BASE + 12'd3;
    #1;
    n_tests++; if (sel !== 1'b1) begin n_fail++; $display("FAIL sel_top got %b exp 1", sel); end
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, d);
    n_tests++; if (d !== 32'hF) begin n_fail++; $display("FAIL mask_width got %h exp f", d); end
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_unmasked got %b exp 1", irq); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_w1c_race();
    test_irq_mask();
    test_simultaneous();
    test_decode();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
